// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped cache controller.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, WB, FILL, REPLAY} state_e;

  localparam int ADDR_W     = 16;
  localparam int OFF_W      = 2;
  localparam int LINE_WORDS = 4;
  localparam int IDX_W_DEF  = 5;
  localparam int TAG_W      = ADDR_W - 3 - IDX_W_DEF;

  function automatic logic [ADDR_W-1:0] tag_of(input logic [ADDR_W-1:0] a, input int idx_w);
    return a >> (3 + idx_w);
  endfunction

  function automatic logic [ADDR_W-1:0] idx_of(input logic [ADDR_W-1:0] a, input int idx_w);
    return (a >> 3) & ((16'd1 << idx_w) - 16'd1);
  endfunction
endpackage

// File: rtl/dm_cache_ctrl_if.sv
// Requester port plus backing-memory port of the cache controller.
interface dm_cache_ctrl_if;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, CacheHit, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ack;

  modport slave (
    input  Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    output DataOut, Done, Stall, CacheHit, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport master (
    output Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    input  DataOut, Done, Stall, CacheHit, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/cache_array.sv
// Tag/data storage with async read; valid/dirty bits clear synchronously on reset.
module cache_array
  import cache_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IDX_W-1:0]         idx_i,
  input  logic [OFF_W-1:0]         off_i,
  input  logic                     we_i,
  input  logic [15:0]              wdata_i,
  input  logic                     wdirty_i,
  input  logic                     line_set_i,
  input  logic [ADDR_W-4-IDX_W:0]  line_tag_i,
  output logic [15:0]              rdata_o,
  output logic [ADDR_W-4-IDX_W:0]  tag_o,
  output logic                     valid_o,
  output logic                     dirty_o
);
  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0]          valid_q, dirty_q;
  logic [ADDR_W-4-IDX_W:0]   tag_q  [LINES];
  logic [15:0]               data_q [LINES*LINE_WORDS];

  assign rdata_o = data_q[{idx_i, off_i}];
  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_set_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (we_i && wdirty_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i)       data_q[{idx_i, off_i}] <= wdata_i;
    if (line_set_i) tag_q[idx_i]           <= line_tag_i;
  end
endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: hits finish in the
// request cycle, misses stall through writeback, refill and a replay cycle.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  dm_cache_ctrl_if.slave  bus
);
  localparam int TW = TAG_W + IDX_W_DEF - IDX_W;

  state_e        state_q;
  logic [1:0]    cnt_q;
  logic          mem_rd_q, mem_wr_q;

  logic [TW-1:0]    req_tag, vic_tag;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       off;
  logic [15:0]      rdata, wdata;
  logic             valid, dirty, req, illegal, hit, last_ack;
  logic             we, wdirty, line_set;

  assign req_tag  = TW'(tag_of(bus.Addr, IDX_W));
  assign req_idx  = IDX_W'(idx_of(bus.Addr, IDX_W));
  assign req      = bus.Rd | bus.Wr;
  assign illegal  = req & ((bus.Rd & bus.Wr) | bus.Addr[0]);
  assign hit      = valid & (vic_tag == req_tag);
  assign last_ack = bus.mem_ack & (cnt_q == 2'd3);
  // During line transfers the array is addressed by the word counter.
  assign off      = (state_q == WB || state_q == FILL) ? cnt_q : bus.Addr[2:1];

  assign bus.mem_rd = mem_rd_q;
  assign bus.mem_wr = mem_wr_q;

  cache_array #(.IDX_W(IDX_W)) u_array (
    .clk       (clk),
    .rst       (rst),
    .idx_i     (req_idx),
    .off_i     (off),
    .we_i      (we),
    .wdata_i   (wdata),
    .wdirty_i  (wdirty),
    .line_set_i(line_set),
    .line_tag_i(req_tag),
    .rdata_o   (rdata),
    .tag_o     (vic_tag),
    .valid_o   (valid),
    .dirty_o   (dirty)
  );

  always_comb begin
    bus.Done      = 1'b0;
    bus.Stall     = 1'b0;
    bus.CacheHit  = 1'b0;
    bus.err       = 1'b0;
    bus.DataOut   = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    we            = 1'b0;
    wdirty        = 1'b0;
    wdata         = bus.DataIn;
    line_set      = 1'b0;
    case (state_q)
      IDLE: begin
        if (illegal) begin
          bus.err  = 1'b1;
          bus.Done = 1'b1;
        end else if (req) begin
          if (hit) begin
            bus.Done     = 1'b1;
            bus.CacheHit = 1'b1;
            bus.DataOut  = bus.Rd ? rdata : '0;
            we           = bus.Wr;
            wdirty       = bus.Wr;
          end else begin
            bus.Stall = 1'b1;
          end
        end
      end
      WB: begin
        bus.Stall     = 1'b1;
        bus.mem_addr  = {vic_tag, req_idx, cnt_q, 1'b0};
        bus.mem_wdata = rdata;
      end
      FILL: begin
        bus.Stall    = 1'b1;
        bus.mem_addr = {req_tag, req_idx, cnt_q, 1'b0};
        we           = bus.mem_ack;
        wdata        = bus.mem_rdata;
        line_set     = last_ack;
      end
      REPLAY: begin
        bus.Done    = 1'b1;
        bus.DataOut = bus.Rd ? rdata : '0;
        we          = bus.Wr;
        wdirty      = bus.Wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !illegal && !hit) begin
            cnt_q <= 2'd0;
            if (valid && dirty) begin
              state_q  <= WB;
              mem_wr_q <= 1'b1;
            end else begin
              state_q  <= FILL;
              mem_rd_q <= 1'b1;
            end
          end
        end
        WB: begin
          if (bus.mem_ack) begin
            cnt_q <= cnt_q + 2'd1;
            if (last_ack) begin
              state_q  <= FILL;
              mem_wr_q <= 1'b0;
              mem_rd_q <= 1'b1;
            end
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            cnt_q <= cnt_q + 2'd1;
            if (last_ack) begin
              state_q  <= REPLAY;
              mem_rd_q <= 1'b0;
            end
          end
        end
        REPLAY:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
